// File: rtl/pkt_rx_sequencer.sv
// Control sequencer for the bit-serial packet-recovery datapath.
// Hunts the sync word, reads the length field, gates payload bits to the consumer,
// drives the CRC engine enable/clear and reports a per-packet verdict with
// saturating good/bad packet counters. All outputs are registered.
module pkt_rx_sequencer #(
    parameter int unsigned          SYNC_W  = 16,
    parameter logic [SYNC_W-1:0]    SYNC    = 16'hA5C3,
    parameter int unsigned          LEN_W   = 8,
    parameter int unsigned          MAX_LEN = 64,
    parameter int unsigned          CRC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             valid_in,
    input  logic             crc_zero,
    output logic             bit_out,
    output logic             data_valid,
    output logic             crc_en,
    output logic             crc_clr,
    output logic             pkt_done,
    output logic             pkt_good,
    output logic             len_err,
    output logic [LEN_W-1:0] pkt_len,
    output logic [15:0]      good_cnt,
    output logic [15:0]      bad_cnt
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN * 8 + 1);

    localparam logic [CNT_W-1:0] LenLast = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] CrcLast = CNT_W'(CRC_W - 1);
    localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPayload,
        StCrc,
        StChk1,
        StChk2
    } state_e;

    state_e              state_q;
    logic [SYNC_W-1:0]   sync_sr_q;
    logic [CNT_W-1:0]    bit_cnt_q;

    logic [SYNC_W-1:0]   sync_next;
    logic [LEN_W-1:0]    len_next;
    logic [LEN_W+2:0]    pay_bits;
    logic [CNT_W-1:0]    pay_last;
    logic                len_bad;

    // Shift-register and length views that include the bit currently on bit_in
    always_comb begin
        sync_next = {sync_sr_q[SYNC_W-2:0], bit_in};
        len_next  = {pkt_len[LEN_W-2:0], bit_in};
        pay_bits  = {pkt_len, 3'b000};
        pay_last  = CNT_W'(pay_bits - 1'b1);
        len_bad   = (len_next == '0) || (len_next > MaxLen);
    end

    // Sequencer FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StHunt;
            sync_sr_q  <= '0;
            bit_cnt_q  <= '0;
            bit_out    <= 1'b0;
            data_valid <= 1'b0;
            crc_en     <= 1'b0;
            crc_clr    <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_good   <= 1'b0;
            len_err    <= 1'b0;
            pkt_len    <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            data_valid <= 1'b0;
            crc_en     <= 1'b0;
            crc_clr    <= 1'b0;
            pkt_done   <= 1'b0;
            len_err    <= 1'b0;

            // The sync window keeps shifting in every state so a packet that
            // follows immediately after the verdict is still caught.
            if (valid_in) begin
                bit_out   <= bit_in;
                sync_sr_q <= sync_next;
            end

            case (state_q)
                StHunt: begin
                    if (valid_in && (sync_next == SYNC)) begin
                        state_q   <= StLen;
                        bit_cnt_q <= '0;
                        crc_clr   <= 1'b1;
                        sync_sr_q <= '0;
                    end
                end
                StLen: begin
                    if (valid_in) begin
                        pkt_len   <= len_next;
                        crc_en    <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LenLast) begin
                            bit_cnt_q <= '0;
                            if (len_bad) begin
                                len_err <= 1'b1;
                                state_q <= StHunt;
                            end else begin
                                state_q <= StPayload;
                            end
                        end
                    end
                end
                StPayload: begin
                    if (valid_in) begin
                        data_valid <= 1'b1;
                        crc_en     <= 1'b1;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == pay_last) begin
                            bit_cnt_q <= '0;
                            state_q   <= StCrc;
                        end
                    end
                end
                StCrc: begin
                    if (valid_in) begin
                        crc_en    <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CrcLast) begin
                            bit_cnt_q <= '0;
                            state_q   <= StChk1;
                        end
                    end
                end
                // Two dead cycles cover the CRC engine's residue latency
                StChk1: state_q <= StChk2;
                StChk2: begin
                    pkt_done <= 1'b1;
                    pkt_good <= crc_zero;
                    if (crc_zero) begin
                        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                    end else begin
                        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
                    end
                    state_q <= StHunt;
                end
                default: state_q <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rx_sequencer.sv
// Self-checking bench for pkt_rx_sequencer: randomized packets, a serial CRC-16
// engine model driving crc_zero, and a queue scoreboard checked by a monitor.
module tb_pkt_rx_sequencer;

    localparam logic [15:0] SYNC = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        crc_zero;
    logic        bit_out, data_valid, crc_en, crc_clr, pkt_done, pkt_good, len_err;
    logic [7:0]  pkt_len;
    logic [15:0] good_cnt, bad_cnt;

    pkt_rx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .valid_in   (valid_in),
        .crc_zero   (crc_zero),
        .bit_out    (bit_out),
        .data_valid (data_valid),
        .crc_en     (crc_en),
        .crc_clr    (crc_clr),
        .pkt_done   (pkt_done),
        .pkt_good   (pkt_good),
        .len_err    (len_err),
        .pkt_len    (pkt_len),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always #5 clk = ~clk;

    // CRC-16 (poly 0x1021, MSB first, init 0)
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    // CRC engine: consumes bit_out on crc_en, residue flag is combinational
    logic [15:0] crc_reg = 16'h0;
    always @(posedge clk) begin
        if (!rst || crc_clr) crc_reg <= 16'h0;
        else if (crc_en)     crc_reg <= crc_step(crc_reg, bit_out);
    end
    assign crc_zero = (crc_reg == 16'h0);

    typedef struct {
        bit is_err;
        bit good;
        int len;
        int dv;
        int ce;
        int gcnt;
        int bcnt;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_data[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: sync window since last detect, packet counters
    bit [15:0] tail = 16'h0;
    int m_good = 0;
    int m_bad  = 0;
    bit gap_rand = 0;
    int gap_at1 = -1;
    int gap_at2 = -1;

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            bit_in = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input bit b);
        if (gap_rand && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        bit_in   = b;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        tail = {tail[14:0], b};
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) begin
            bit_in   = 1'($urandom);
            valid_in = 1'b1;
            @(posedge clk); #1;
        end
        rst      = 1'b1;
        valid_in = 1'b0;
        tail     = 16'h0;
        m_good   = 0;
        m_bad    = 0;
        exp_q.delete();
        exp_data.delete();
    endtask

    // True when the only sync occurrence in tail+preamble+sync is at its very end
    function automatic bit sync_only_at_end(input bit pre[$]);
        bit [15:0] w;
        bit        s[$];
        w = tail;
        s = pre;
        for (int k = 15; k >= 0; k--) s.push_back(SYNC[k]);
        for (int k = 0; k < s.size(); k++) begin
            w = {w[14:0], s[k]};
            if (w == SYNC && k != s.size() - 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic send_pkt(input int len, input bit corrupt, input int abort_at);
        bit        pre[$];
        bit        pay[$];
        bit [7:0]  lv;
        bit [15:0] crc;
        int        nb;
        exp_t      e;
        do begin
            pre.delete();
            repeat ($urandom_range(0, 8)) pre.push_back(1'($urandom));
        end while (!sync_only_at_end(pre));

        lv  = 8'(len);
        nb  = (len >= 1 && len <= 64) ? len * 8 : 0;
        crc = 16'h0;
        for (int k = 7; k >= 0; k--) crc = crc_step(crc, lv[k]);
        for (int k = 0; k < nb; k++) begin
            pay.push_back(1'($urandom));
            crc = crc_step(crc, pay[k]);
        end
        if (corrupt && nb > 0) begin
            int p;
            p = $urandom_range(0, nb - 1);
            pay[p] = ~pay[p];
        end

        e.is_err = (nb == 0);
        e.good   = !corrupt;
        e.len    = len & 255;
        e.dv     = nb;
        e.ce     = (nb == 0) ? 8 : 8 + nb + 16;
        if (nb != 0) begin
            if (corrupt) m_bad++;
            else         m_good++;
        end
        e.gcnt = m_good;
        e.bcnt = m_bad;
        exp_q.push_back(e);
        foreach (pay[k]) exp_data.push_back(pay[k]);

        foreach (pre[k]) drive(pre[k]);
        for (int k = 15; k >= 0; k--) drive(SYNC[k]);
        tail = 16'h0;
        for (int k = 7; k >= 0; k--) drive(lv[k]);
        for (int k = 0; k < nb; k++) begin
            if (k == abort_at) begin
                do_reset(1);
                return;
            end
            if (k == gap_at1 || k == gap_at2) idle(3);
            drive(pay[k]);
        end
        if (nb != 0) for (int k = 15; k >= 0; k--) drive(crc[k]);
    endtask

    // Monitor: per-cycle checks and event scoreboard, sampled on the falling edge
    logic last_rst = 1'b1;
    logic last_v   = 1'b0;
    always @(posedge clk) begin
        last_rst <= rst;
        last_v   <= valid_in;
    end

    int dv_cnt = 0;
    int ce_cnt = 0;
    int clr_cnt = 0;
    bit hold_good = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!last_rst) begin
            check("reset_outputs", {17'h0, bit_out, data_valid, crc_en, crc_clr, pkt_done,
                                    pkt_good, len_err, pkt_len}, 32'h0);
            check("reset_counters", {good_cnt, bad_cnt}, 32'h0);
            dv_cnt = 0;
            ce_cnt = 0;
            clr_cnt = 0;
            hold_good = 1'b0;
        end else begin
            if (!last_v) check("gap_quiet", {30'h0, data_valid, crc_en}, 32'h0);
            if (data_valid) begin
                dv_cnt++;
                check("data_expected", 32'(exp_data.size() != 0), 32'd1);
                if (exp_data.size() != 0) check("payload_bit", 32'(bit_out), 32'(exp_data.pop_front()));
            end
            if (crc_en)  ce_cnt++;
            if (crc_clr) clr_cnt++;
            if (pkt_done || len_err) begin
                check("event_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("event_kind", {30'h0, pkt_done, len_err}, e.is_err ? 32'd1 : 32'd2);
                    if (!e.is_err) begin
                        check("pkt_good", 32'(pkt_good), 32'(e.good));
                        hold_good = e.good;
                    end
                    check("pkt_len", 32'(pkt_len), e.len);
                    check("data_valid_count", dv_cnt, e.dv);
                    check("crc_en_count", ce_cnt, e.ce);
                    check("crc_clr_count", clr_cnt, 32'd1);
                    check("good_cnt", 32'(good_cnt), e.gcnt);
                    check("bad_cnt", 32'(bad_cnt), e.bcnt);
                end
                dv_cnt = 0;
                ce_cnt = 0;
                clr_cnt = 0;
            end else begin
                check("good_hold", 32'(pkt_good), 32'(hold_good));
            end
        end
    end

    initial begin
        int waited;
        // Reset held with live random bits
        do_reset(20);
        idle(3);
        // Good packet, then corrupted packet from a fresh reset
        send_pkt(2, 1'b0, -1);
        idle(5);
        do_reset(2);
        send_pkt(2, 1'b1, -1);
        // Illegal lengths, then a legal one
        send_pkt(0, 1'b0, -1);
        send_pkt(65, 1'b0, -1);
        send_pkt(2, 1'b0, -1);
        // Length boundaries
        send_pkt(1, 1'b0, -1);
        send_pkt(64, 1'b0, -1);
        send_pkt(255, 1'b0, -1);
        // Two forced 3-cycle gaps mid-payload
        gap_at1 = 4;
        gap_at2 = 10;
        send_pkt(2, 1'b0, -1);
        gap_at1 = -1;
        gap_at2 = -1;
        // Random traffic with random gaps and corruption
        gap_rand = 1'b1;
        repeat (12) send_pkt($urandom_range(0, 10), 1'($urandom_range(0, 3) == 0), -1);
        gap_rand = 1'b0;
        // Reset mid-payload, then a normal packet
        send_pkt(3, 1'b0, 9);
        send_pkt(2, 1'b0, -1);
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(3);
        check("drain_events", exp_q.size(), 32'd0);
        check("drain_data", exp_data.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
